// File: rtl/mips_host_ctrl.sv
// rtl/mips_host_ctrl.sv - host-side load/run/readback initiator for the MIPS kernel
//
// Holds the kernel in reset while streaming the program into instruction
// memory and preloading data memory, releases the kernel, waits for its done
// pulse, then reads a window of data memory back out as a valid/ready stream.
//
// Optional build macro: MIPS_HOST_TIMEOUT_EN adds a RUN-phase watchdog that
// abandons readback after TIMEOUT_CYCLES and raises the sticky o_timeout flag.
//
// Ports:
//   i_sys_clk, i_sys_rst           clock, synchronous active-high reset
//   i_start + job fields           i_num_inst, i_num_data, i_rd_base, i_num_rd
//   i_inst_valid/o_inst_ready      instruction stream in (i_inst_data)
//   i_data_valid/o_data_ready      preload stream in (i_data)
//   o_krnl_rst                     kernel reset, active high
//   o_inst_mem_data/_wr_en         instruction-memory write port
//   o_host_mem_wr_en/_rd_en        data-memory strobes, o_host_addr, o_host_din
//   i_host_dout                    data-memory read data, RD_LAT cycles after rd_en
//   i_krnl_done                    kernel-done pulse
//   o_res_valid/i_res_ready        result stream out (o_res_data)
//   o_busy, o_done, o_timeout      status
module mips_host_ctrl #(
    parameter int WORD_W         = 32,
    parameter int ADDR_W         = 10,
    parameter int RD_LAT         = 1,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              i_sys_clk,
    input  logic              i_sys_rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_num_inst,
    input  logic [ADDR_W-1:0] i_num_data,
    input  logic [ADDR_W-1:0] i_rd_base,
    input  logic [ADDR_W-1:0] i_num_rd,
    input  logic              i_inst_valid,
    output logic              o_inst_ready,
    input  logic [WORD_W-1:0] i_inst_data,
    input  logic              i_data_valid,
    output logic              o_data_ready,
    input  logic [WORD_W-1:0] i_data,
    output logic              o_krnl_rst,
    output logic [WORD_W-1:0] o_inst_mem_data,
    output logic              o_inst_mem_wr_en,
    output logic              o_host_mem_wr_en,
    output logic              o_host_mem_rd_en,
    output logic [ADDR_W-1:0] o_host_addr,
    output logic [WORD_W-1:0] o_host_din,
    input  logic [WORD_W-1:0] i_host_dout,
    input  logic              i_krnl_done,
    output logic              o_res_valid,
    input  logic              i_res_ready,
    output logic [WORD_W-1:0] o_res_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_timeout
);

    localparam int                LAT_W    = $clog2(RD_LAT + 1);
    localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(RD_LAT);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_INST,
        S_LOAD_DATA,
        S_RUN,
        S_READ_REQ,
        S_READ_WAIT,
        S_READ_OUT,
        S_FINISH
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] num_inst_q;
    logic [ADDR_W-1:0] num_data_q;
    logic [ADDR_W-1:0] rd_base_q;
    logic [ADDR_W-1:0] num_rd_q;
    logic [ADDR_W-1:0] cnt;        // shared word index for every phase
    logic [LAT_W-1:0]  lat_cnt;

`ifdef MIPS_HOST_TIMEOUT_EN
    localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt;
    logic            timeout_q;

    assign o_timeout = timeout_q;
`else
    assign o_timeout = 1'b0;
`endif

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            state            <= S_IDLE;
            num_inst_q       <= '0;
            num_data_q       <= '0;
            rd_base_q        <= '0;
            num_rd_q         <= '0;
            cnt              <= '0;
            lat_cnt          <= '0;
            o_inst_ready     <= 1'b0;
            o_data_ready     <= 1'b0;
            o_krnl_rst       <= 1'b1;
            o_inst_mem_data  <= '0;
            o_inst_mem_wr_en <= 1'b0;
            o_host_mem_wr_en <= 1'b0;
            o_host_mem_rd_en <= 1'b0;
            o_host_addr      <= '0;
            o_host_din       <= '0;
            o_res_valid      <= 1'b0;
            o_res_data       <= '0;
            o_busy           <= 1'b0;
            o_done           <= 1'b0;
`ifdef MIPS_HOST_TIMEOUT_EN
            wd_cnt           <= '0;
            timeout_q        <= 1'b0;
`endif
        end else begin
            // Strobes are single-cycle unless a state re-asserts them.
            o_inst_mem_wr_en <= 1'b0;
            o_host_mem_wr_en <= 1'b0;
            o_host_mem_rd_en <= 1'b0;
            o_done           <= 1'b0;

            unique case (state)
                S_IDLE: begin
                    if (i_start) begin
                        num_inst_q   <= i_num_inst;
                        num_data_q   <= i_num_data;
                        rd_base_q    <= i_rd_base;
                        num_rd_q     <= i_num_rd;
                        cnt          <= '0;
                        o_busy       <= 1'b1;
                        o_inst_ready <= (i_num_inst != '0);
                        state        <= S_LOAD_INST;
`ifdef MIPS_HOST_TIMEOUT_EN
                        timeout_q    <= 1'b0;
`endif
                    end
                end

                S_LOAD_INST: begin
                    if (num_inst_q == '0) begin
                        o_data_ready <= (num_data_q != '0);
                        state        <= S_LOAD_DATA;
                    end else if (i_inst_valid && o_inst_ready) begin
                        o_inst_mem_wr_en <= 1'b1;
                        o_inst_mem_data  <= i_inst_data;
                        if (cnt == num_inst_q - ONE) begin
                            cnt          <= '0;
                            o_inst_ready <= 1'b0;
                            o_data_ready <= (num_data_q != '0);
                            state        <= S_LOAD_DATA;
                        end else begin
                            cnt <= cnt + ONE;
                        end
                    end
                end

                S_LOAD_DATA: begin
                    if (num_data_q == '0) begin
                        o_krnl_rst <= 1'b0;
                        state      <= S_RUN;
`ifdef MIPS_HOST_TIMEOUT_EN
                        wd_cnt     <= '0;
`endif
                    end else if (i_data_valid && o_data_ready) begin
                        o_host_mem_wr_en <= 1'b1;
                        o_host_addr      <= cnt;
                        o_host_din       <= i_data;
                        if (cnt == num_data_q - ONE) begin
                            cnt          <= '0;
                            o_data_ready <= 1'b0;
                            o_krnl_rst   <= 1'b0;
                            state        <= S_RUN;
`ifdef MIPS_HOST_TIMEOUT_EN
                            wd_cnt       <= '0;
`endif
                        end else begin
                            cnt <= cnt + ONE;
                        end
                    end
                end

                S_RUN: begin
                    if (i_krnl_done) begin
                        cnt <= '0;
                        if (num_rd_q == '0) begin
                            o_done     <= 1'b1;
                            o_krnl_rst <= 1'b1;
                            state      <= S_FINISH;
                        end else begin
                            o_host_mem_rd_en <= 1'b1;
                            o_host_addr      <= rd_base_q;
                            state            <= S_READ_REQ;
                        end
`ifdef MIPS_HOST_TIMEOUT_EN
                    end else if (wd_cnt == WD_LAST) begin
                        timeout_q  <= 1'b1;
                        o_done     <= 1'b1;
                        o_krnl_rst <= 1'b1;
                        state      <= S_FINISH;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
`endif
                    end
                end

                // The read strobe was raised on entry; it drops here.
                S_READ_REQ: begin
                    lat_cnt <= LAT_W'(1);
                    state   <= S_READ_WAIT;
                end

                S_READ_WAIT: begin
                    if (lat_cnt == LAT_LAST) begin
                        o_res_data  <= i_host_dout;
                        o_res_valid <= 1'b1;
                        state       <= S_READ_OUT;
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end

                S_READ_OUT: begin
                    if (i_res_ready) begin
                        o_res_valid <= 1'b0;
                        if (cnt == num_rd_q - ONE) begin
                            o_done     <= 1'b1;
                            o_krnl_rst <= 1'b1;
                            state      <= S_FINISH;
                        end else begin
                            // Address arithmetic wraps modulo the memory size.
                            cnt              <= cnt + ONE;
                            o_host_mem_rd_en <= 1'b1;
                            o_host_addr      <= rd_base_q + cnt + ONE;
                            state            <= S_READ_REQ;
                        end
                    end
                end

                S_FINISH: begin
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
